// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the instruction fetch slice.
// Contents: XLEN, the NOP encoding, the fetch FSM state enum, the fetch
// buffer entry struct, the empty-entry constant and a word-align helper.
package riscv_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // An empty slot presents a NOP at pc 0 so the outputs come straight from registers.
  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, instr: NOP_INSTR};

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// 2-entry synchronous fetch buffer (shift style: the head always sits in slot 0).
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   clear           drop all entries (wins over push/pop)
//   push, push_data write an entry; legal when full if pop is also high
//   pop             remove the head
//   head            registered head entry (EMPTY_ENTRY when empty)
//   full, empty     occupancy flags; count = occupancy 0..2
module if_fetch_buf
  import riscv_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t slot0_r, slot1_r;
  fetch_entry_t slot0_nxt_s, slot1_nxt_s;
  logic [1:0]   cnt_r, cnt_nxt_s, cnt_mid_s;
  logic         pop_s, push_s;

  // Next-state computation: pop shifts slot1 forward, push fills the first free slot.
  always_comb begin
    pop_s       = pop && (cnt_r != 2'd0);
    push_s      = push && ((cnt_r != 2'd2) || pop_s);
    slot0_nxt_s = slot0_r;
    slot1_nxt_s = slot1_r;
    if (pop_s) begin
      slot0_nxt_s = (cnt_r == 2'd2) ? slot1_r : EMPTY_ENTRY;
      slot1_nxt_s = EMPTY_ENTRY;
    end else begin
      slot0_nxt_s = slot0_r;
      slot1_nxt_s = slot1_r;
    end
    cnt_mid_s = cnt_r - {1'b0, pop_s};
    if (push_s) begin
      if (cnt_mid_s == 2'd0) begin
        slot0_nxt_s = push_data;
      end else begin
        slot1_nxt_s = push_data;
      end
    end else begin
      cnt_mid_s = cnt_mid_s;
    end
    cnt_nxt_s = cnt_mid_s + {1'b0, push_s};
  end

  // Storage registers; clear empties the buffer regardless of push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0_r <= EMPTY_ENTRY;
      slot1_r <= EMPTY_ENTRY;
      cnt_r   <= 2'd0;
    end else if (clear) begin
      slot0_r <= EMPTY_ENTRY;
      slot1_r <= EMPTY_ENTRY;
      cnt_r   <= 2'd0;
    end else begin
      slot0_r <= slot0_nxt_s;
      slot1_r <= slot1_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign head  = slot0_r;
  assign full  = (cnt_r == 2'd2);
  assign empty = (cnt_r == 2'd0);
  assign count = cnt_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues word fetches, pairs in-order responses with
// their pc and presents them to the IF/ID register through a 2-entry buffer.
// Optional feature macro: IF_MISALIGN_TRAP_EN adds misalign_o.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   stall                         ID does not consume this cycle
//   redirect_valid, redirect_pc   taken branch/jump and its target
//   imem_req, imem_addr           fetch request and word address
//   imem_gnt, imem_rvalid, imem_rdata  grant, in-order response, data
//   instruction_w, sig_pc_w, valid_o   buffer head to IF/ID
//   flush                         active-low IF/ID flush, one cycle per redirect
//   misalign_o                    (macro only) redirect target not word aligned
module if_fetch_unit
  import riscv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction_w,
  output logic [XLEN-1:0] sig_pc_w,
  output logic            valid_o,
`ifdef IF_MISALIGN_TRAP_EN
  output logic            misalign_o,
`endif
  output logic            flush
);

  fetch_state_e    state_r, state_nxt_s;
  logic [XLEN-1:0] pc_r, pc_nxt_s;
  logic [XLEN-1:0] pcq0_r, pcq1_r, pcq0_nxt_s, pcq1_nxt_s;
  logic [1:0]      out_r, out_nxt_s, disc_r, disc_nxt_s, slot_s;
  logic            req_r, req_nxt_s, flush_r;
  logic            gnt_s, rsp_s, keep_s, pop_s, buf_push_s;
  logic [2:0]      occ_nxt_s, credit_s;
  logic            buf_full_s, buf_empty_s;
  logic [1:0]      buf_count_s;
  fetch_entry_t    rsp_entry_s, head_s;

  // Per-cycle bookkeeping: grants, responses, discard count, pc FIFO and credits.
  always_comb begin
    gnt_s       = req_r && imem_gnt;
    rsp_s       = imem_rvalid && (out_r != 2'd0);
    // A response is kept only when nothing is pending discard and no redirect is flushing it.
    keep_s      = rsp_s && (disc_r == 2'd0) && !redirect_valid;
    pop_s       = valid_o && !stall;
    buf_push_s  = keep_s && (!buf_full_s || pop_s);
    rsp_entry_s = '{pc: pcq0_r, instr: imem_rdata};
    out_nxt_s   = out_r + {1'b0, gnt_s} - {1'b0, rsp_s};

    // Every transaction still in flight after a redirect cycle belongs to the old path.
    if (redirect_valid) begin
      disc_nxt_s = out_nxt_s;
    end else if (rsp_s && (disc_r != 2'd0)) begin
      disc_nxt_s = disc_r - 2'd1;
    end else begin
      disc_nxt_s = disc_r;
    end

    if (redirect_valid) begin
      pc_nxt_s = align_word(redirect_pc);
    end else if (gnt_s) begin
      pc_nxt_s = pc_r + 32'd4;
    end else begin
      pc_nxt_s = pc_r;
    end

    // pc FIFO: head in pcq0, a response shifts, a grant lands behind the survivors.
    slot_s     = out_r - {1'b0, rsp_s};
    pcq0_nxt_s = rsp_s ? pcq1_r : pcq0_r;
    pcq1_nxt_s = pcq1_r;
    if (gnt_s) begin
      if (slot_s == 2'd0) begin
        pcq0_nxt_s = pc_r;
      end else begin
        pcq1_nxt_s = pc_r;
      end
    end else begin
      pcq1_nxt_s = pcq1_r;
    end

    case (state_r)
      BOOT:    state_nxt_s = RUN;
      RUN:     state_nxt_s = (redirect_valid && (disc_nxt_s != 2'd0)) ? DRAIN : RUN;
      DRAIN:   state_nxt_s = (disc_nxt_s != 2'd0) ? DRAIN : RUN;
      default: state_nxt_s = BOOT;
    endcase

    // The request is registered, so credits are judged on next-cycle occupancy.
    occ_nxt_s = redirect_valid ? 3'd0
              : ({1'b0, buf_count_s} + {2'b00, buf_push_s} - {2'b00, pop_s});
    credit_s  = {1'b0, out_nxt_s} + occ_nxt_s;
    req_nxt_s = (state_nxt_s == RUN) && (credit_s < 3'd2);
  end

  // FSM and fetch-side state with registered request and flush outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= BOOT;
      pc_r    <= RESET_PC;
      out_r   <= 2'd0;
      disc_r  <= 2'd0;
      pcq0_r  <= 32'h0000_0000;
      pcq1_r  <= 32'h0000_0000;
      req_r   <= 1'b0;
      flush_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      out_r   <= out_nxt_s;
      disc_r  <= disc_nxt_s;
      pcq0_r  <= pcq0_nxt_s;
      pcq1_r  <= pcq1_nxt_s;
      req_r   <= req_nxt_s;
      flush_r <= !redirect_valid;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_r;

  // One-cycle pulse for a redirect target that is not word aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  assign misalign_o = misalign_r;
`endif

  if_fetch_buf u_fetch_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (buf_push_s),
    .push_data (rsp_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (buf_full_s),
    .empty     (buf_empty_s),
    .count     (buf_count_s)
  );

  assign imem_req      = req_r;
  assign imem_addr     = pc_r;
  assign flush         = flush_r;
  assign valid_o       = !buf_empty_s;
  assign instruction_w = head_s.instr;
  assign sig_pc_w      = head_s.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit. A small in-order memory answers each
// grant one cycle later with data equal to the address; every consumed
// instruction is compared with the next expected pc of the current path.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instruction_w, sig_pc_w;
  logic        valid_o, flush;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] pend[$];
  logic        auto_rsp;
  int          wrap_hits;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instruction_w  (instruction_w),
    .sig_pc_w       (sig_pc_w),
    .valid_o        (valid_o),
`ifdef IF_MISALIGN_TRAP_EN
    .misalign_o     (misalign_o),
`endif
    .flush          (flush)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, called at a negedge: log consumption, clock, then drive the memory side.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    logic        wrap_now;
    g = imem_req && imem_gnt;
    a = imem_addr;
    if (reset && valid_o && !stall && !redirect_valid) begin
      check_eq("seq_pc", sig_pc_w, exp_pc);
      check_eq("seq_instr", instruction_w, exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    wrap_now = g && (a == 32'hFFFF_FFFC) && !redirect_valid;
    @(posedge clk);
    @(negedge clk);
    if (g && reset) pend.push_back(a);
    if (wrap_now) begin
      check_eq("wrap_addr", imem_addr, 32'h0000_0000);
      wrap_hits++;
    end
    if (auto_rsp && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend.pop_front();
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0000_0000;
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    auto_rsp = 1'b1; exp_pc = 32'h0; wrap_hits = 0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0000_0000);
    check_eq("rst_flush", {31'b0, flush}, 32'd1);
    check_eq("rst_valid", {31'b0, valid_o}, 32'd0);
    check_eq("rst_instr", instruction_w, 32'h0000_0013);
    check_eq("rst_pc", sig_pc_w, 32'h0000_0000);

    // Release: BOOT cycle has no request, then first request at RESET_PC
    reset = 1'b1;
    tick();
    check_eq("boot_req", {31'b0, imem_req}, 32'd1);
    check_eq("boot_addr", imem_addr, 32'h0000_0000);

    // Streaming
    repeat (20) tick();
    check_eq("stream_progress", {31'b0, (exp_pc >= 32'd16)}, 32'd1);

    // Stall with full buffer: no requests, head frozen
    stall = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_req", {31'b0, imem_req}, 32'd0);
      check_eq("stall_valid", {31'b0, valid_o}, 32'd1);
      check_eq("stall_hold", sig_pc_w, exp_pc);
      tick();
    end
    stall = 1'b0;
    repeat (10) tick();

    // Redirect with two responses outstanding
    auto_rsp = 1'b0;
    repeat (6) tick();
    check_eq("credit_req", {31'b0, imem_req}, 32'd0);
    check_eq("credit_pend", pend.size(), 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    exp_pc = 32'h0000_0100;
    check_eq("redir_flush", {31'b0, flush}, 32'd0);
    check_eq("redir_valid", {31'b0, valid_o}, 32'd0);
    auto_rsp = 1'b1;
    tick();
    check_eq("redir_flush_end", {31'b0, flush}, 32'd1);
    check_eq("drain_req", {31'b0, imem_req}, 32'd0);
    repeat (12) tick();
    check_eq("redir_progress", {31'b0, (exp_pc >= 32'h0000_0108)}, 32'd1);

    // Address wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF0;
    tick();
    redirect_valid = 1'b0;
    exp_pc = 32'hFFFF_FFF0;
    repeat (16) tick();
    check_eq("wrap_seen", wrap_hits, 32'd1);
    check_eq("wrap_progress", {31'b0, (exp_pc < 32'hFFFF_FFF0) && (exp_pc >= 32'd4)}, 32'd1);

    // Redirect and stall in the same cycle: redirect wins
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    exp_pc = 32'h0000_0200;
    check_eq("rs_valid", {31'b0, valid_o}, 32'd0);
    check_eq("rs_flush", {31'b0, flush}, 32'd0);
    check_eq("rs_addr", imem_addr, 32'h0000_0200);
    repeat (10) tick();
    check_eq("rs_progress", {31'b0, (exp_pc >= 32'h0000_0208)}, 32'd1);

`ifdef IF_MISALIGN_TRAP_EN
    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    exp_pc = 32'h0000_0100;
    check_eq("mis_pulse", {31'b0, misalign_o}, 32'd1);
    check_eq("mis_addr", imem_addr, 32'h0000_0100);
    tick();
    check_eq("mis_clear", {31'b0, misalign_o}, 32'd0);
    repeat (10) tick();
`endif

    // Reset with a response in flight; stray rvalid after release is ignored
    auto_rsp = 1'b0;
    repeat (2) tick();
    check_eq("rst2_pend", {31'b0, (pend.size() > 0)}, 32'd1);
    reset = 1'b0;
    pend.delete();
    #1;
    check_eq("rst2_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst2_valid", {31'b0, valid_o}, 32'd0);
    @(negedge clk);
    tick();
    reset = 1'b1;
    auto_rsp = 1'b1;
    exp_pc = 32'h0000_0000;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check_eq("rst2_first_req", {31'b0, imem_req}, 32'd1);
    check_eq("rst2_first_addr", imem_addr, 32'h0000_0000);
    check_eq("rst2_stray", {31'b0, valid_o}, 32'd0);
    repeat (12) tick();
    check_eq("rst2_progress", {31'b0, (exp_pc >= 32'd8)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 RESET_PC SHALL be a parameter, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hazard unit hold; 1 means ID does not consume this cycle.
REQ-005 redirect_valid  input  1  branch/jump taken; redirect_pc  input  32  target address.
REQ-006 imem_req  output  1  fetch request; imem_addr  output  32  word address of request.
REQ-007 imem_gnt  input  1  request accepted this cycle; imem_rvalid  input  1  in-order response valid; imem_rdata  input  32  response data.
REQ-008 instruction_w  output  32  and sig_pc_w  output  32  instruction and its PC, feeding the IF/ID register.
REQ-009 valid_o  output  1  instruction_w/sig_pc_w hold a real instruction.
REQ-010 flush  output  1  active-low IF/ID flush, low for exactly one cycle per redirect.

Function
REQ-011 pc SHALL be a 32-bit register; imem_addr = pc; pc SHALL advance by 4 on each cycle with imem_req && imem_gnt, wrapping 32'hFFFF_FFFC -> 0.
REQ-012 Credits: outstanding (0..2) + buffer occupancy (0..2) SHALL never exceed 2; imem_req SHALL be high only when the sum < 2 and state is RUN.
REQ-013 A 2-entry pc FIFO SHALL record each granted address; each imem_rvalid SHALL pair imem_rdata with the oldest recorded pc and push both into the fetch buffer.
REQ-014 instruction_w/sig_pc_w/valid_o SHALL be driven from the buffer head registers; no combinational path from imem_rdata to outputs (response in cycle N visible in N+1).
REQ-015 With the buffer empty, valid_o = 0, instruction_w = 32'h0000_0013 (NOP), sig_pc_w = 0.
REQ-016 The head SHALL pop when valid_o && !stall; under stall the outputs SHALL hold.
REQ-017 Simultaneous push and pop on a full buffer SHALL be legal and preserve order.
REQ-018 FSM states: BOOT (one cycle after reset release, no request) -> RUN; RUN -> DRAIN on redirect_valid with outstanding > 0; RUN -> RUN on redirect_valid with outstanding = 0; DRAIN -> RUN when the last discarded response arrives.
REQ-019 On redirect_valid: pc <= redirect_pc, buffer cleared, flush low next cycle, no grant that cycle advances pc; all responses outstanding at redirect time SHALL be discarded.
REQ-020 redirect_valid SHALL take priority over stall and over a same-cycle grant; a redirect during DRAIN SHALL update pc and extend the discard count.
REQ-021 imem_rvalid with zero outstanding SHALL be ignored.

Reset
REQ-022 On reset low: pc = RESET_PC, state = BOOT, buffer and pc FIFO empty, outstanding = 0, imem_req = 0, flush = 1, valid_o = 0, instruction_w = NOP, sig_pc_w = 0.
REQ-023 Reset asserted mid-transaction SHALL drop all in-flight responses; the memory side is reset in the same domain.

Configuration
REQ-024 Macro IF_MISALIGN_TRAP_EN defined: extra output misalign_o (1 bit) pulses high one cycle when redirect_pc[1:0] != 0, the redirect is still taken with pc = {redirect_pc[31:2],2'b00}.
REQ-025 Macro undefined: no misalign_o port; redirect_pc[1:0] silently forced to 2'b00.

Structure
REQ-026 Package riscv_pipe_pkg SHALL hold XLEN = 32, NOP_INSTR = 32'h0000_0013, the FSM state enum (BOOT, RUN, DRAIN) and the fetch-buffer entry struct {pc, instr}.
REQ-027 Sub-module if_fetch_buf (2-entry synchronous FIFO, push/pop/full/empty/clear) SHALL implement the fetch buffer.

Verification
REQ-028 Reset release, gnt = 1, 1-cycle rvalid returning data = address -> sig_pc_w sequence 0,4,8,... with valid_o, no gaps after fill.
REQ-029 stall held 5 cycles with buffer full -> imem_req = 0, outputs frozen, sequence resumes without loss or duplication.
REQ-030 redirect_valid with redirect_pc = 32'h0000_0100 while 2 outstanding -> flush low one cycle, both late responses dropped, next valid_o has sig_pc_w = 32'h100.
REQ-031 pc = 32'hFFFF_FFFC granted -> next imem_addr = 0.
REQ-032 redirect and stall same cycle, and reset asserted with 1 outstanding -> redirect wins; after reset, first imem_req at RESET_PC, stray rvalid ignored.
REQ-033 With IF_MISALIGN_TRAP_EN, redirect_pc = 32'h0000_0102 -> misalign_o pulses once, next fetch at 32'h100.
